ysyx22041405_ifu_fetch: RTL and testbench
=========================================

// Module: ysyx22041405_ifu_fetch
// PURPOSE
//   Instruction fetch unit: consumer end of the EXU next-PC interface. Holds the architectural
//   fetch PC, issues one outstanding request at a time to instruction memory (valid/ready),
//   and hands each fetched instruction to the IDU through a valid/ready skid register.
//   EXU redirects (taken branch/jump) squash any wrong-path fetch in flight or held.
// PARAMETERS
//   WIDTH     32            address/data width
//   RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
//   clk                 in   1      core clock
//   rst                 in   1      asynchronous, active-low reset
//   exu_redirect_valid  in   1      one-cycle pulse: EXU resolved a non-sequential PC
//   exu_next_pc         in   WIDTH  redirect target, sampled only with exu_redirect_valid
//   imem_req_valid      out  1      fetch request valid
//   imem_req_ready      in   1      imem accepts request
//   imem_req_addr       out  WIDTH  fetch address, stable while imem_req_valid && !imem_req_ready
//   imem_rsp_valid      in   1      response valid (exactly one per accepted request, >=1 cycle later)
//   imem_rsp_data       in   32     instruction word
//   imem_rsp_err        in   1      access fault for this response
//   if_valid            out  1      instruction available to IDU
//   if_ready            in   1      IDU accepts instruction
//   if_pc               out  WIDTH  PC of held instruction
//   if_inst             out  32     held instruction
//   if_fault            out  1      held slot is a fetch fault (if_inst = 0)
// BEHAVIOUR
//   - Regs: state, pc_q (next PC), faddr_q (outstanding addr), kill_q, held slot {pc,inst,fault}.
//   - Reset: state=IDLE, pc_q=RESET_PC, kill_q=0; all outputs 0 (imem_req_addr=0, if_inst=0).
//   - FSM: IDLE -> REQ unconditionally (first request cycle after reset release).
//     REQ : imem_req_valid=1, imem_req_addr=faddr_q (loaded from pc_q on entering REQ).
//           req handshake -> WAIT.
//     WAIT: on imem_rsp_valid: kill_q=1 -> drop response, kill_q<=0, faddr_q<=pc_q, -> REQ;
//           else capture {faddr_q, rsp_data, rsp_err} into held slot, -> HOLD.
//     HOLD: if_valid=1, slot outputs stable; on if_ready: pc_q<=if_pc+4, -> REQ.
//   - if_fault=1 on rsp_err; if_inst forced to 0; PC still advances by 4 on accept.
//   - Latency: req handshake cycle N, rsp cycle M>N, if_valid at M+1; next req at accept+1.
//   - pc+4 wraps modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000), no flag.
//   - Redirect (priority over every other update; pc_q<=exu_next_pc in all states):
//     IDLE/REQ: request already visible cannot be withdrawn -> kill_q<=1; stay REQ until
//       handshake, then WAIT; killed response dropped, re-fetch at target.
//     WAIT: kill_q<=1; response in the same cycle as redirect is dropped.
//     HOLD: held slot discarded (if_valid=0 next cycle) even if if_ready same cycle; -> REQ.
//   - Back-to-back redirects: last target wins; kill_q stays set, only one response dropped.
//   - imem_rsp_valid outside WAIT is ignored. Async reset mid-transaction: all state cleared
//     immediately; imem is reset by the same rst, so no stale response is expected.
// CONFIGURATION
//   YSYX22041405_IFU_MISALIGN_EN
//     defined  : pc_q[1:0]!=0 when entering REQ -> no imem request; held slot filled with
//                {pc_q, 0, fault=1}, -> HOLD directly.
//     undefined: no check; imem_req_addr[1:0] forced to 2'b00, if_pc reports aligned addr.
// TESTING
//   1. Release reset, req_ready=1, rsp 1 cycle later 0x00000413, if_ready=1 -> req addr
//      0x8000_0000, if_pc=0x8000_0000, if_inst=0x00000413; next req addr 0x8000_0004.
//   2. if_ready=0 for 5 cycles in HOLD -> if_valid/if_pc/if_inst unchanged, imem_req_valid=0.
//   3. Redirect to 0x8000_0100 while in WAIT for 0x8000_0004 -> that response dropped
//      (if_valid stays 0), next req addr 0x8000_0100.
//   4. Redirect to 0x8000_0100 in HOLD same cycle as if_ready=1 -> slot dropped, no
//      if_valid&&if_ready beat counted, next req 0x8000_0100.
//   5. req_ready=0 for 3 cycles with redirect in cycle 1 -> addr held at old value until
//      handshake, response dropped, then req 0x8000_0100; rsp_err=1 on it -> if_fault=1, if_inst=0.
//   6. Redirect to 0x8000_0102: macro defined -> no request, if_fault=1, if_pc=0x8000_0102;
//      undefined -> req addr 0x8000_0100.

Source files
------------

// File: rtl/ysyx22041405_ifu_fetch_if.sv
// ysyx22041405_ifu_fetch_if: instruction-memory request/response bus plus the IFU->IDU instruction handoff.
interface ysyx22041405_ifu_fetch_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             imem_rsp_err;
  logic             if_valid;
  logic             if_ready;
  logic [WIDTH-1:0] if_pc;
  logic [31:0]      if_inst;
  logic             if_fault;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, if_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, if_ready
  );
endinterface

// File: rtl/ysyx22041405_ifu_fetch.sv
// ysyx22041405_ifu_fetch: single-outstanding instruction fetch with redirect squash and held IDU slot.
// Optional YSYX22041405_IFU_MISALIGN_EN turns misaligned fetch PCs into fault slots instead of aligning them.
module ysyx22041405_ifu_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exu_redirect_valid,
  input  logic [WIDTH-1:0]     exu_next_pc,
  ysyx22041405_ifu_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, faddr_q, hold_pc_q, hold_pc_d;
  logic [31:0]      hold_inst_q, hold_inst_d;
  logic             hold_fault_q, hold_fault_d, kill_q, kill_d, misal, load_faddr;
`ifdef YSYX22041405_IFU_MISALIGN_EN
  localparam logic [WIDTH-1:0] ADDR_MASK = '1;
  assign misal = faddr_q[1:0] != 2'b00;
`else
  localparam logic [WIDTH-1:0] ADDR_MASK = ~WIDTH'(3);
  assign misal = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_pc_d    = hold_pc_q;
    hold_inst_d  = hold_inst_q;
    hold_fault_d = hold_fault_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        kill_d  = kill_q | exu_redirect_valid;
      end
      REQ: begin
        if (misal) begin
          state_d      = exu_redirect_valid ? REQ : HOLD;
          hold_pc_d    = exu_redirect_valid ? hold_pc_q : faddr_q;
          hold_inst_d  = exu_redirect_valid ? hold_inst_q : 32'h0;
          hold_fault_d = exu_redirect_valid ? hold_fault_q : 1'b1;
        end else begin
          kill_d  = kill_q | exu_redirect_valid;
          state_d = bus.imem_req_ready ? WAIT : REQ;
        end
      end
      WAIT: begin
        // A response arriving with a redirect is the squashed one, so the kill is consumed here.
        if (bus.imem_rsp_valid && (kill_q || exu_redirect_valid)) begin
          kill_d  = 1'b0;
          state_d = REQ;
        end else if (bus.imem_rsp_valid) begin
          state_d      = HOLD;
          hold_pc_d    = faddr_q;
          hold_inst_d  = bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
          hold_fault_d = bus.imem_rsp_err;
        end else begin
          kill_d = kill_q | exu_redirect_valid;
        end
      end
      HOLD: begin
        state_d = (exu_redirect_valid || bus.if_ready) ? REQ : HOLD;
        pc_d    = bus.if_ready ? hold_pc_q + WIDTH'(4) : pc_q;
      end
    endcase
    if (exu_redirect_valid) pc_d = exu_next_pc;
    load_faddr = state_d == REQ && (state_q != REQ || misal);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      faddr_q      <= '0;
      kill_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_inst_q  <= 32'h0;
      hold_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      hold_pc_q    <= hold_pc_d;
      hold_inst_q  <= hold_inst_d;
      hold_fault_q <= hold_fault_d;
      if (load_faddr) faddr_q <= pc_d & ADDR_MASK;
    end
  end
  assign bus.imem_req_valid = state_q == REQ && !misal;
  assign bus.imem_req_addr  = faddr_q;
  assign bus.if_valid       = state_q == HOLD;
  assign bus.if_pc          = hold_pc_q;
  assign bus.if_inst        = hold_inst_q;
  assign bus.if_fault       = hold_fault_q;
endmodule

// File: tb/tb_ysyx22041405_ifu_fetch.sv
// tb_ysyx22041405_ifu_fetch: directed fetch/redirect scenarios with request and delivery scoreboards.
module tb_ysyx22041405_ifu_fetch;
  logic        clk, rst, redirect;
  logic [31:0] next_pc;
  int          errors = 0, checks = 0, rsp_delay = 1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] exp_req[$];
  logic [64:0] exp_beat[$];
  ysyx22041405_ifu_fetch_if #(.WIDTH(32)) bus ();
  ysyx22041405_ifu_fetch #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .exu_redirect_valid(redirect), .exu_next_pc(next_pc), .bus(bus.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : a ^ 32'h1357_9bdf;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.if_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.if_valid), 32'h1);
  endtask
  // Instruction memory: one response per accepted request, rsp_delay cycles after the handshake.
  initial begin
    logic        h, pend;
    logic [31:0] ha, paddr;
    int          left;
    pend = 1'b0; left = 0; paddr = 32'h0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0; bus.imem_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      h  = bus.imem_req_valid && bus.imem_req_ready;
      ha = bus.imem_req_addr;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (h) begin pend = 1'b1; left = rsp_delay; paddr = ha; end
      if (pend) begin
        if (left <= 1) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_data(paddr);
          bus.imem_rsp_err   = err_en && paddr == err_addr;
          pend = 1'b0;
        end else left--;
      end
    end
  end
  // Scoreboard pops: request addresses at handshake, slots at accepted IDU beats.
  initial forever begin
    @(negedge clk);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      if (exp_req.size() == 0) chk("unexpected_req", bus.imem_req_addr, 32'hxxxx_xxxx);
      else chk("req_addr", bus.imem_req_addr, exp_req.pop_front());
    end
    if (bus.if_valid && bus.if_ready && !redirect) begin
      logic [64:0] e;
      if (exp_beat.size() == 0) chk("unexpected_beat", bus.if_pc, 32'hxxxx_xxxx);
      else begin
        e = exp_beat.pop_front();
        chk("beat_pc", bus.if_pc, e[64:33]);
        chk("beat_inst", bus.if_inst, e[32:1]);
        chk("beat_fault", 32'(bus.if_fault), 32'(e[0]));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b0; redirect = 1'b0; next_pc = 32'h0;
    bus.imem_req_ready = 1'b1; bus.if_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_inst", bus.if_inst, 32'h0);
    chk("rst_if_fault", 32'(bus.if_fault), 32'h0);
    exp_req.push_back(32'h8000_0000);
    exp_beat.push_back({32'h8000_0000, 32'h0000_0413, 1'b0});
    rst = 1'b1;
    wait_valid("first_valid");
    chk("first_pc", bus.if_pc, 32'h8000_0000);
    chk("first_inst", bus.if_inst, 32'h0000_0413);
    repeat (5) begin
      tick();
      chk("stall_valid", 32'(bus.if_valid), 32'h1);
      chk("stall_pc", bus.if_pc, 32'h8000_0000);
      chk("stall_inst", bus.if_inst, 32'h0000_0413);
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
    end
    exp_req.push_back(32'h8000_0004);
    rsp_delay = 4;
    bus.if_ready = 1'b1; tick(); bus.if_ready = 1'b0;
    chk("req_after_accept", 32'(bus.imem_req_valid), 32'h1);
    tick();
    exp_req.push_back(32'h8000_0100);
    redirect = 1'b1; next_pc = 32'h8000_0100; tick(); redirect = 1'b0;
    rsp_delay = 1;
    repeat (4) begin
      chk("wait_kill_no_valid", 32'(bus.if_valid), 32'h0);
      tick();
    end
    wait_valid("refetch_valid");
    chk("refetch_pc", bus.if_pc, 32'h8000_0100);
    chk("refetch_inst", bus.if_inst, mem_data(32'h8000_0100));
    exp_req.push_back(32'h8000_0100);
    redirect = 1'b1; next_pc = 32'h8000_0100; bus.if_ready = 1'b1;
    tick();
    redirect = 1'b0; bus.if_ready = 1'b0;
    chk("hold_redirect_drop", 32'(bus.if_valid), 32'h0);
    exp_beat.push_back({32'h8000_0100, mem_data(32'h8000_0100), 1'b0});
    wait_valid("hold_refetch_valid");
    chk("hold_refetch_pc", bus.if_pc, 32'h8000_0100);
    bus.imem_req_ready = 1'b0;
    exp_req.push_back(32'h8000_0104);
    exp_req.push_back(32'h8000_0100);
    bus.if_ready = 1'b1; tick(); bus.if_ready = 1'b0;
    chk("stallreq_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("stallreq_addr", bus.imem_req_addr, 32'h8000_0104);
    redirect = 1'b1; next_pc = 32'h8000_0100; tick(); redirect = 1'b0;
    repeat (2) begin
      chk("stallreq_valid_held", 32'(bus.imem_req_valid), 32'h1);
      chk("stallreq_addr_held", bus.imem_req_addr, 32'h8000_0104);
      tick();
    end
    bus.imem_req_ready = 1'b1; err_en = 1'b1; err_addr = 32'h8000_0100;
    exp_beat.push_back({32'h8000_0100, 32'h0, 1'b1});
    wait_valid("fault_valid");
    chk("fault_pc", bus.if_pc, 32'h8000_0100);
    chk("fault_flag", 32'(bus.if_fault), 32'h1);
    chk("fault_inst", bus.if_inst, 32'h0);
    err_en = 1'b0;
    exp_req.push_back(32'h8000_0104);
    bus.if_ready = 1'b1; tick(); bus.if_ready = 1'b0;
    wait_valid("after_fault_valid");
    chk("after_fault_pc", bus.if_pc, 32'h8000_0104);
    chk("after_fault_flag", 32'(bus.if_fault), 32'h0);
`ifndef YSYX22041405_IFU_MISALIGN_EN
    exp_req.push_back(32'h8000_0100);
`endif
    redirect = 1'b1; next_pc = 32'h8000_0102; tick(); redirect = 1'b0;
    wait_valid("misalign_valid");
`ifdef YSYX22041405_IFU_MISALIGN_EN
    chk("misalign_pc", bus.if_pc, 32'h8000_0102);
    chk("misalign_fault", 32'(bus.if_fault), 32'h1);
    chk("misalign_inst", bus.if_inst, 32'h0);
`else
    chk("misalign_pc", bus.if_pc, 32'h8000_0100);
    chk("misalign_fault", 32'(bus.if_fault), 32'h0);
    chk("misalign_inst", bus.if_inst, mem_data(32'h8000_0100));
`endif
    exp_req.push_back(32'hffff_fffc);
    exp_beat.push_back({32'hffff_fffc, mem_data(32'hffff_fffc), 1'b0});
    redirect = 1'b1; next_pc = 32'hffff_fffc; tick(); redirect = 1'b0;
    wait_valid("wrap_top_valid");
    chk("wrap_top_pc", bus.if_pc, 32'hffff_fffc);
    exp_req.push_back(32'h0000_0000);
    bus.if_ready = 1'b1; tick(); bus.if_ready = 1'b0;
    wait_valid("wrap_zero_valid");
    chk("wrap_zero_pc", bus.if_pc, 32'h0000_0000);
    chk("wrap_zero_inst", bus.if_inst, mem_data(32'h0000_0000));
    repeat (3) tick();
    chk("req_queue_drained", 32'(exp_req.size()), 32'h0);
    chk("beat_queue_drained", 32'(exp_beat.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
